// File: rtl/mux_sel_arbiter_if.sv
// Requester-side bundle for the shared 10:1 select mux arbiter.
interface mux_sel_arbiter_if;
    localparam int unsigned N  = 10;
    localparam int unsigned SW = 4;

    logic [N-1:0]  req;
    logic          rel;
    logic [N-1:0]  gnt;
    logic [SW-1:0] sel;
    logic          busy;
    logic          timeout;

    modport master (output req, rel, input gnt, sel, busy, timeout);
    modport slave  (input req, rel, output gnt, sel, busy, timeout);
endinterface

// File: rtl/mux_sel_arbiter.sv
// Round-robin owner arbiter for the 10:1 select mux; drives one-hot gnt and binary sel.
// Optional grant watchdog built when MUX_SEL_ARB_TIMEOUT_EN is defined.
module mux_sel_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    mux_sel_arbiter_if.slave bus
);
    localparam int unsigned   N    = 10;
    localparam int unsigned   SW   = 4;
    localparam int unsigned   CW   = 5;
    localparam logic [SW-1:0] LAST = SW'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [SW-1:0] ptr_q, ptr_d;
    logic          busy_q, busy_d;
    logic [SW-1:0] pick_c;
    logic          found_c;
    logic          own_c;
    logic          expire_c;
    logic          end_c;

    // First requester at or after ptr, wrapping 9 -> 0
    always_comb begin
        logic [CW-1:0] idx;
        pick_c  = '0;
        found_c = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = CW'(ptr_q) + CW'(i);
            if (idx >= CW'(N)) idx = idx - CW'(N);
            if (!found_c && bus.req[SW'(idx)]) begin
                found_c = 1'b1;
                pick_c  = SW'(idx);
            end
        end
    end

    // All end conditions collapse into one release
    assign own_c = bus.req[sel_q];
    assign end_c = (state_q == GRANT) && (bus.rel || !own_c || expire_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (found_c) state_d = GRANT;
            GRANT:   if (end_c)   state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // sel only moves on a new grant; GAP is the mux turnaround cycle
    always_comb begin
        gnt_d  = gnt_q;
        sel_d  = sel_q;
        ptr_d  = ptr_q;
        busy_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (found_c) begin
                    gnt_d  = N'(1) << pick_c;
                    sel_d  = pick_c;
                    busy_d = 1'b1;
                end
            end
            GRANT: begin
                if (end_c) begin
                    gnt_d = '0;
                    ptr_d = (sel_q == LAST) ? '0 : sel_q + SW'(1);
                end else begin
                    busy_d = 1'b1;
                end
            end
            GAP:     gnt_d = '0;
            default: gnt_d = '0;
        endcase
    end

`ifdef MUX_SEL_ARB_TIMEOUT_EN
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;

    assign expire_c = (cnt_q == CW'(MAX_HOLD - 1));

    // Watchdog only reports when it is the sole reason the grant ended
    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = (state_q == GRANT) && expire_c && !bus.rel && own_c;
        if (state_q == IDLE && found_c) begin
            cnt_d = '0;
        end else if (state_q == GRANT && !end_c) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`else
    logic unused_hold;
    assign unused_hold = ^(CW'(MAX_HOLD));
    assign expire_c    = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    assign bus.gnt  = gnt_q;
    assign bus.sel  = sel_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed plus random checks of mux_sel_arbiter against an owner/cooldown reference model.
module tb_mux_sel_arbiter;
`ifdef MUX_SEL_ARB_TIMEOUT_EN
    localparam int unsigned MAX_HOLD = 4;
    localparam bit          TO_EN    = 1'b1;
`else
    localparam int unsigned MAX_HOLD = 16;
    localparam bit          TO_EN    = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    mux_sel_arbiter_if bus ();

    mux_sel_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the mux, for how long, and turnaround cycles left
    int m_owner;
    int m_ptr;
    int m_sel;
    int m_cool;
    int m_held;
    bit m_tmo;

    function automatic void model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_sel   = 0;
        m_cool  = 0;
        m_held  = 0;
        m_tmo   = 1'b0;
    endfunction

    function automatic void model_edge(input logic [9:0] r, input logic l);
        m_tmo = 1'b0;
        if (m_owner >= 0) begin
            m_held++;
            if (l || !r[m_owner] || (TO_EN && m_held >= int'(MAX_HOLD))) begin
                m_tmo   = TO_EN && (m_held >= int'(MAX_HOLD)) && !l && r[m_owner];
                m_ptr   = (m_owner + 1) % 10;
                m_owner = -1;
                m_cool  = 1;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (r != 10'd0) begin
            for (int k = 0; k < 10; k++) begin
                int i;
                i = (m_ptr + k) % 10;
                if (r[i]) begin
                    m_owner = i;
                    m_sel   = i;
                    m_held  = 0;
                    break;
                end
            end
        end
    endfunction

    task automatic check_val(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [9:0] eg;
        eg = (m_owner >= 0) ? (10'b1 << m_owner) : 10'd0;
        checks++;
        assert (bus.gnt === eg) else begin
            errors++;
            $error("FAIL %s gnt observed=%h expected=%h", tag, bus.gnt, eg);
        end
        checks++;
        assert (bus.sel === 4'(m_sel)) else begin
            errors++;
            $error("FAIL %s sel observed=%h expected=%h", tag, bus.sel, 4'(m_sel));
        end
        checks++;
        assert (bus.busy === (m_owner >= 0)) else begin
            errors++;
            $error("FAIL %s busy observed=%b expected=%b", tag, bus.busy, (m_owner >= 0));
        end
        checks++;
        assert (bus.timeout === m_tmo) else begin
            errors++;
            $error("FAIL %s timeout observed=%b expected=%b", tag, bus.timeout, m_tmo);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge(bus.req, bus.rel);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input logic [9:0] r);
        rst_n   = 1'b0;
        bus.req = r;
        bus.rel = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;
    endtask

    int  order[$];
    logic prev_busy;

    initial begin
        rst_n   = 1'b1;
        bus.req = '0;
        bus.rel = 1'b0;
        #2;

        // Reset with all requests pending, then first arbitration
        do_reset(10'h3FF);
        check_val("reset_gnt", bus.gnt, 10'h000);
        check_val("reset_sel", 10'(bus.sel), 10'h000);
        step("first_grant");
        check_val("first_gnt", bus.gnt, 10'h001);
        check_val("first_sel", 10'(bus.sel), 10'h000);

        // Single requester, release at t+3
        do_reset(10'h000);
        bus.req = 10'h008;
        step("single_t");
        check_val("single_gnt", bus.gnt, 10'h008);
        check_val("single_sel", 10'(bus.sel), 10'h003);
        step("single_t1");
        step("single_t2");
        bus.rel = 1'b1;
        step("single_t3");
        bus.rel = 1'b0;
        check_val("single_rel_gnt", bus.gnt, 10'h000);
        check_val("single_rel_busy", 10'(bus.busy), 10'h000);

        // Rotation with release on the second grant cycle
        do_reset(10'h3FF);
        prev_busy = 1'b0;
        for (int n = 0; n < 50; n++) begin
            bus.rel = (m_owner >= 0) && (m_held == 1);
            step("rotate");
            if (bus.busy && !prev_busy) order.push_back(int'(bus.sel));
            prev_busy = bus.busy;
        end
        bus.rel = 1'b0;
        check_val("rotate_count", 10'(order.size() >= 11), 10'h001);
        for (int k = 0; k < 11; k++) begin
            if (k < order.size()) check_val("rotate_order", 10'(order[k]), 10'(k % 10));
        end

        // Wrap priority after owner 9
        do_reset(10'h200);
        step("wrap_g9");
        check_val("wrap_g9", bus.gnt, 10'h200);
        bus.rel = 1'b1;
        step("wrap_rel9");
        bus.rel = 1'b0;
        bus.req = 10'h101;
        step("wrap_gap");
        step("wrap_arb");
        check_val("wrap_g0", bus.gnt, 10'h001);
        bus.rel = 1'b1;
        step("wrap_rel0");
        bus.rel = 1'b0;
        step("wrap_gap2");
        step("wrap_arb2");
        check_val("wrap_g8", bus.gnt, 10'h100);

        // Watchdog / indefinite hold
        do_reset(10'h000);
        bus.req = 10'h060;
`ifdef MUX_SEL_ARB_TIMEOUT_EN
        for (int n = 0; n < 4; n++) begin
            step("wd_hold");
            check_val("wd_hold_gnt", bus.gnt, 10'h020);
        end
        step("wd_gap");
        check_val("wd_tmo", 10'(bus.timeout), 10'h001);
        check_val("wd_gap_gnt", bus.gnt, 10'h000);
        step("wd_idle");
        check_val("wd_tmo_clr", 10'(bus.timeout), 10'h000);
        step("wd_next");
        check_val("wd_next_gnt", bus.gnt, 10'h040);
`else
        for (int n = 0; n < 100; n++) begin
            step("hold");
            check_val("hold_gnt", bus.gnt, 10'h020);
            check_val("hold_tmo", 10'(bus.timeout), 10'h000);
        end
`endif

        // Reset in the middle of a grant
        do_reset(10'h000);
        bus.req = 10'h080;
        step("mid_g7");
        check_val("mid_g7", bus.gnt, 10'h080);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_val("mid_rst_gnt", bus.gnt, 10'h000);
        check_val("mid_rst_sel", 10'(bus.sel), 10'h000);
        check_all("mid_rst");
        #2;
        rst_n   = 1'b1;
        bus.req = 10'h280;
        step("mid_after");
        check_val("mid_after_gnt", bus.gnt, 10'h080);

        // Random traffic against the model
        do_reset(10'h000);
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) bus.req = 10'($urandom) & 10'($urandom);
            bus.rel = ($urandom_range(0, 3) == 0);
            step("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
